// File: rtl/axis_frame_pad_trunc_pkg.sv
// Shared FSM encodings and the tkeep popcount helper for axis_frame_pad_trunc.
package axis_frame_pad_trunc_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
   localparam logic [1:0] ST_PAD  = 2'd2;
   localparam logic [1:0] ST_DROP = 2'd3;

   localparam int POP_MAX_WIDTH = 64;

   function automatic logic [7:0] popcount(input logic [POP_MAX_WIDTH-1:0] v);
      logic [7:0] n;
      n = '0;
      for (int i = 0; i < POP_MAX_WIDTH; i++) begin
         n = n + {7'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/axis_frame_pad_trunc_out_reg.sv
// Single AXIS output register stage; carries per-beat padded/truncated tags for status.
module axis_frame_pad_trunc_out_reg
   import axis_frame_pad_trunc_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 8,
   parameter int DEST_WIDTH = 8,
   parameter int USER_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [KEEP_WIDTH-1:0] in_keep,
   input  logic                  in_last,
   input  logic [ID_WIDTH-1:0]   in_id,
   input  logic [DEST_WIDTH-1:0] in_dest,
   input  logic [USER_WIDTH-1:0] in_user,
   input  logic                  in_padded,
   input  logic                  in_trunc,
   output logic                  load,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [ID_WIDTH-1:0]   m_axis_tid,
   output logic [DEST_WIDTH-1:0] m_axis_tdest,
   output logic [USER_WIDTH-1:0] m_axis_tuser,
   output logic                  out_padded,
   output logic                  out_trunc
);

   logic                  valid_reg;
   logic [DATA_WIDTH-1:0] data_reg;
   logic [KEEP_WIDTH-1:0] keep_reg;
   logic                  last_reg;
   logic [ID_WIDTH-1:0]   id_reg;
   logic [DEST_WIDTH-1:0] dest_reg;
   logic [USER_WIDTH-1:0] user_reg;
   logic                  padded_reg;
   logic                  trunc_reg;

   assign load = !valid_reg || m_axis_tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg  <= 1'b0;
         data_reg   <= '0;
         keep_reg   <= '0;
         last_reg   <= 1'b0;
         id_reg     <= '0;
         dest_reg   <= '0;
         user_reg   <= '0;
         padded_reg <= 1'b0;
         trunc_reg  <= 1'b0;
      end else if (load) begin
         valid_reg  <= in_valid;
         data_reg   <= in_data;
         keep_reg   <= in_keep;
         last_reg   <= in_last;
         id_reg     <= in_id;
         dest_reg   <= in_dest;
         user_reg   <= in_user;
         padded_reg <= in_padded;
         trunc_reg  <= in_trunc;
      end
   end

   assign m_axis_tvalid = valid_reg;
   assign m_axis_tdata  = data_reg;
   assign m_axis_tkeep  = keep_reg;
   assign m_axis_tlast  = last_reg;
   assign m_axis_tid    = id_reg;
   assign m_axis_tdest  = dest_reg;
   assign m_axis_tuser  = user_reg;
   assign out_padded    = padded_reg;
   assign out_trunc     = trunc_reg;

endmodule

// File: rtl/axis_frame_pad_trunc.sv
// AXIS frame length conditioner: zero-pads short frames, truncates long ones with bad tuser.
// Optional AXIS_FRAME_PAD_LEN_OUT_EN adds status_frame_len / status_frame_len_valid.
module axis_frame_pad_trunc
   import axis_frame_pad_trunc_pkg::*;
#(
   parameter int                        DATA_WIDTH           = 8,
   parameter int                        KEEP_WIDTH           = DATA_WIDTH / 8,
   parameter int                        ID_WIDTH             = 8,
   parameter int                        DEST_WIDTH           = 8,
   parameter int                        USER_WIDTH           = 1,
   parameter int                        MIN_LENGTH           = 64,
   parameter int                        MAX_LENGTH           = 1522,
   parameter logic [USER_WIDTH-1:0]     USER_BAD_FRAME_VALUE = USER_WIDTH'(1'b1),
   parameter logic [USER_WIDTH-1:0]     USER_BAD_FRAME_MASK  = USER_WIDTH'(1'b1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [ID_WIDTH-1:0]   s_axis_tid,
   input  logic [DEST_WIDTH-1:0] s_axis_tdest,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [ID_WIDTH-1:0]   m_axis_tid,
   output logic [DEST_WIDTH-1:0] m_axis_tdest,
   output logic [USER_WIDTH-1:0] m_axis_tuser,
   output logic                  status_padded,
   output logic                  status_truncated
`ifdef AXIS_FRAME_PAD_LEN_OUT_EN
   ,
   output logic [$clog2(MAX_LENGTH+1)-1:0] status_frame_len,
   output logic                            status_frame_len_valid
`endif
);

   localparam int            CW    = $clog2(MAX_LENGTH + 1);
   localparam logic [CW-1:0] MIN_W = CW'(MIN_LENGTH);
   localparam logic [CW-1:0] MAX_W = CW'(MAX_LENGTH);
   localparam logic [CW-1:0] KW_W  = CW'(KEEP_WIDTH);

   logic [1:0]            state_reg, state_next;
   logic [CW-1:0]         cnt_reg, cnt_next;
   logic [CW-1:0]         cnt_sum, cnt_round;
   logic [ID_WIDTH-1:0]   id_hold_reg, id_hold_next;
   logic [DEST_WIDTH-1:0] dest_hold_reg, dest_hold_next;
   logic [USER_WIDTH-1:0] user_hold_reg, user_hold_next;
   logic                  ready_en_reg;
   logic                  status_padded_reg, status_truncated_reg;

   logic                     load, in_frame, s_fire, accept_end;
   logic [POP_MAX_WIDTH-1:0] keep_ext;
   logic [DATA_WIDTH-1:0]    byte_mask;

   logic                  ov_valid, ov_last, ov_padded, ov_trunc;
   logic [DATA_WIDTH-1:0] ov_data;
   logic [KEEP_WIDTH-1:0] ov_keep;
   logic [ID_WIDTH-1:0]   ov_id;
   logic [DEST_WIDTH-1:0] ov_dest;
   logic [USER_WIDTH-1:0] ov_user;
   logic                  out_padded, out_trunc;

   for (genvar gi = 0; gi < KEEP_WIDTH; gi++) begin : g_byte_mask
      assign byte_mask[gi*8 +: 8] = {8{s_axis_tkeep[gi]}};
   end

   assign keep_ext  = POP_MAX_WIDTH'(s_axis_tkeep);
   assign cnt_sum   = cnt_reg + CW'(popcount(keep_ext));
   // Count is always a whole number of beats before the last beat, so round-up is one beat on.
   assign cnt_round = cnt_reg + KW_W;

   assign in_frame      = (state_reg == ST_IDLE) || (state_reg == ST_XFER);
   assign s_axis_tready = ready_en_reg && ((in_frame && load) || (state_reg == ST_DROP));
   assign s_fire        = s_axis_tvalid && s_axis_tready;

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      id_hold_next   = id_hold_reg;
      dest_hold_next = dest_hold_reg;
      user_hold_next = user_hold_reg;
      ov_valid       = 1'b0;
      ov_data        = s_axis_tdata;
      ov_keep        = s_axis_tkeep;
      ov_last        = s_axis_tlast;
      ov_id          = s_axis_tid;
      ov_dest        = s_axis_tdest;
      ov_user        = s_axis_tuser;
      ov_padded      = 1'b0;
      ov_trunc       = 1'b0;
      case (state_reg)
         ST_IDLE, ST_XFER: begin
            if (s_fire) begin
               ov_valid       = 1'b1;
               cnt_next       = cnt_sum;
               state_next     = ST_XFER;
               id_hold_next   = s_axis_tid;
               dest_hold_next = s_axis_tdest;
               user_hold_next = s_axis_tuser;
               if (s_axis_tlast) begin
                  if (cnt_sum >= MIN_W) begin
                     cnt_next   = '0;
                     state_next = ST_IDLE;
                  end else begin
                     ov_data = s_axis_tdata & byte_mask;
                     ov_keep = '1;
                     if (cnt_round == MIN_W) begin
                        ov_padded  = 1'b1;
                        cnt_next   = '0;
                        state_next = ST_IDLE;
                     end else begin
                        ov_last    = 1'b0;
                        cnt_next   = cnt_round;
                        state_next = ST_PAD;
                     end
                  end
               end else if (cnt_sum == MAX_W) begin
                  ov_last    = 1'b1;
                  ov_user    = (s_axis_tuser & ~USER_BAD_FRAME_MASK) |
                               (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK);
                  ov_trunc   = 1'b1;
                  cnt_next   = '0;
                  state_next = ST_DROP;
               end
            end
         end
         ST_PAD: begin
            if (load) begin
               ov_valid = 1'b1;
               ov_data  = '0;
               ov_keep  = '1;
               ov_id    = id_hold_reg;
               ov_dest  = dest_hold_reg;
               ov_user  = user_hold_reg;
               cnt_next = cnt_round;
               ov_last  = 1'b0;
               if (cnt_round == MIN_W) begin
                  ov_last    = 1'b1;
                  ov_padded  = 1'b1;
                  cnt_next   = '0;
                  state_next = ST_IDLE;
               end
            end
         end
         ST_DROP: begin
            if (s_fire && s_axis_tlast) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg            <= ST_IDLE;
         cnt_reg              <= '0;
         id_hold_reg          <= '0;
         dest_hold_reg        <= '0;
         user_hold_reg        <= '0;
         ready_en_reg         <= 1'b0;
         status_padded_reg    <= 1'b0;
         status_truncated_reg <= 1'b0;
      end else begin
         state_reg            <= state_next;
         cnt_reg              <= cnt_next;
         id_hold_reg          <= id_hold_next;
         dest_hold_reg        <= dest_hold_next;
         user_hold_reg        <= user_hold_next;
         ready_en_reg         <= 1'b1;
         status_padded_reg    <= accept_end && out_padded;
         status_truncated_reg <= accept_end && out_trunc;
      end
   end

   assign accept_end       = m_axis_tvalid && m_axis_tready && m_axis_tlast;
   assign status_padded    = status_padded_reg;
   assign status_truncated = status_truncated_reg;

`ifdef AXIS_FRAME_PAD_LEN_OUT_EN
   logic [CW-1:0] len_hold_reg, len_out_reg;
   logic          len_valid_reg;

   // Captured at the input end of a frame; an earlier frame's last beat always leaves the output first.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_hold_reg  <= '0;
         len_out_reg   <= '0;
         len_valid_reg <= 1'b0;
      end else begin
         if (in_frame && s_fire && (s_axis_tlast || cnt_sum == MAX_W)) begin
            len_hold_reg <= cnt_sum;
         end
         len_valid_reg <= accept_end;
         if (accept_end) begin
            len_out_reg <= len_hold_reg;
         end
      end
   end

   assign status_frame_len       = len_out_reg;
   assign status_frame_len_valid = len_valid_reg;
`endif

   axis_frame_pad_trunc_out_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .KEEP_WIDTH (KEEP_WIDTH),
      .ID_WIDTH   (ID_WIDTH),
      .DEST_WIDTH (DEST_WIDTH),
      .USER_WIDTH (USER_WIDTH)
   ) u_out_reg (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (ov_valid),
      .in_data       (ov_data),
      .in_keep       (ov_keep),
      .in_last       (ov_last),
      .in_id         (ov_id),
      .in_dest       (ov_dest),
      .in_user       (ov_user),
      .in_padded     (ov_padded),
      .in_trunc      (ov_trunc),
      .load          (load),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tid    (m_axis_tid),
      .m_axis_tdest  (m_axis_tdest),
      .m_axis_tuser  (m_axis_tuser),
      .out_padded    (out_padded),
      .out_trunc     (out_trunc)
   );

endmodule

// File: tb/tb_axis_frame_pad_trunc.sv
// Directed bench for axis_frame_pad_trunc with KEEP_WIDTH=4, MIN_LENGTH=16, MAX_LENGTH=64.
module tb_axis_frame_pad_trunc;

   localparam int DW   = 32;
   localparam int KW   = 4;
   localparam int MINL = 16;
   localparam int MAXL = 64;
   localparam int CW   = $clog2(MAXL + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] s_tdata;
   logic [KW-1:0] s_tkeep;
   logic          s_tvalid;
   logic          s_tready;
   logic          s_tlast;
   logic [7:0]    s_tid;
   logic [7:0]    s_tdest;
   logic [0:0]    s_tuser;
   logic [DW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic          m_tvalid;
   logic          m_tready = 1'b1;
   logic          m_tlast;
   logic [7:0]    m_tid;
   logic [7:0]    m_tdest;
   logic [0:0]    m_tuser;
   logic          status_padded;
   logic          status_truncated;
`ifdef AXIS_FRAME_PAD_LEN_OUT_EN
   logic [CW-1:0] status_frame_len;
   logic          status_frame_len_valid;
`endif

   always #5 clk = ~clk;

   axis_frame_pad_trunc #(
      .DATA_WIDTH (DW),
      .KEEP_WIDTH (KW),
      .ID_WIDTH   (8),
      .DEST_WIDTH (8),
      .USER_WIDTH (1),
      .MIN_LENGTH (MINL),
      .MAX_LENGTH (MAXL)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .s_axis_tdata     (s_tdata),
      .s_axis_tkeep     (s_tkeep),
      .s_axis_tvalid    (s_tvalid),
      .s_axis_tready    (s_tready),
      .s_axis_tlast     (s_tlast),
      .s_axis_tid       (s_tid),
      .s_axis_tdest     (s_tdest),
      .s_axis_tuser     (s_tuser),
      .m_axis_tdata     (m_tdata),
      .m_axis_tkeep     (m_tkeep),
      .m_axis_tvalid    (m_tvalid),
      .m_axis_tready    (m_tready),
      .m_axis_tlast     (m_tlast),
      .m_axis_tid       (m_tid),
      .m_axis_tdest     (m_tdest),
      .m_axis_tuser     (m_tuser),
      .status_padded    (status_padded),
      .status_truncated (status_truncated)
`ifdef AXIS_FRAME_PAD_LEN_OUT_EN
      ,
      .status_frame_len       (status_frame_len),
      .status_frame_len_valid (status_frame_len_valid)
`endif
   );

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      logic        user;
      logic [7:0]  id;
   } beat_t;

   beat_t out_q[$];
   beat_t exp_q[$];
   beat_t mon_b;

   int checks = 0;
   int failures = 0;
   int pad_cnt = 0;
   int trunc_cnt = 0;
   int stall_viol = 0;
   int cyc = 0;
   int first_in_cyc = -1;
   int first_out_cyc = -1;
   bit rand_mode = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   logic        prev_last = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      m_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Output beats and status pulses, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (m_tvalid && m_tready) begin
            mon_b.data = m_tdata;
            mon_b.keep = m_tkeep;
            mon_b.last = m_tlast;
            mon_b.user = m_tuser[0];
            mon_b.id   = m_tid;
            out_q.push_back(mon_b);
            if (first_out_cyc < 0) first_out_cyc = cyc;
         end
         if (s_tvalid && s_tready && first_in_cyc < 0) first_in_cyc = cyc;
         if (status_padded) pad_cnt++;
         if (status_truncated) trunc_cnt++;
         if (prev_stall && (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last))
            stall_viol++;
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] wordbeat(input int seed, input int b);
      logic [31:0] w;
      for (int l = 0; l < 4; l++) w[8*l +: 8] = 8'(seed + 4*b + l);
      return w;
   endfunction

   task automatic push_exp(input logic [31:0] d, input logic last, input logic user, input int seed);
      beat_t e;
      e.data = d;
      e.keep = 4'hF;
      e.last = last;
      e.user = user;
      e.id   = 8'(seed);
      exp_q.push_back(e);
   endtask

   task automatic reset_mon();
      out_q.delete();
      exp_q.delete();
      pad_cnt       = 0;
      trunc_cnt     = 0;
      first_in_cyc  = -1;
      first_out_cyc = -1;
   endtask

   task automatic send_frame(input int seed, input int nwords);
      int nbeats;
      int g;
      bit ok;
      nbeats = (nwords + 3) / 4;
      for (int b = 0; b < nbeats; b++) begin
         for (int l = 0; l < 4; l++) begin
            if (4*b + l < nwords) begin
               s_tdata[8*l +: 8] = 8'(seed + 4*b + l);
               s_tkeep[l]        = 1'b1;
            end else begin
               s_tdata[8*l +: 8] = 8'hAA;
               s_tkeep[l]        = 1'b0;
            end
         end
         s_tlast  = (b == nbeats - 1);
         s_tid    = 8'(seed);
         s_tdest  = 8'h3C;
         s_tuser  = 1'b0;
         s_tvalid = 1'b1;
         g  = 0;
         ok = 1'b0;
         while (!ok && g < 200) begin
            @(negedge clk);
            ok = s_tready;
            @(posedge clk);
            #1;
            g++;
         end
         chk($sformatf("s%0d.b%0d.accept", seed, b), 64'(ok), 64'd1);
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain_and_compare(input string tag);
      int g;
      g = 0;
      while (out_q.size() < exp_q.size() && g < 400) begin
         @(negedge clk);
         g++;
      end
      repeat (6) @(negedge clk);
      chk({tag, ".beats"}, 64'(out_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         chk($sformatf("%s.b%0d.data", tag, i), 64'(out_q[i].data), 64'(exp_q[i].data));
         chk($sformatf("%s.b%0d.keep", tag, i), 64'(out_q[i].keep), 64'(exp_q[i].keep));
         chk($sformatf("%s.b%0d.last", tag, i), 64'(out_q[i].last), 64'(exp_q[i].last));
         chk($sformatf("%s.b%0d.user", tag, i), 64'(out_q[i].user), 64'(exp_q[i].user));
         chk($sformatf("%s.b%0d.id", tag, i), 64'(out_q[i].id), 64'(exp_q[i].id));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic case_20(input int seed, input string tag, input bit lat);
      reset_mon();
      for (int b = 0; b < 5; b++) push_exp(wordbeat(seed, b), b == 4, 1'b0, seed);
      send_frame(seed, 20);
      drain_and_compare(tag);
      chk({tag, ".padded"}, 64'(pad_cnt), 64'd0);
      chk({tag, ".trunc"}, 64'(trunc_cnt), 64'd0);
      if (lat) chk({tag, ".latency"}, 64'(first_out_cyc - first_in_cyc), 64'd1);
   endtask

   task automatic case_6(input int seed, input string tag);
      reset_mon();
      push_exp(wordbeat(seed, 0), 1'b0, 1'b0, seed);
      push_exp({16'h0000, 8'(seed + 5), 8'(seed + 4)}, 1'b0, 1'b0, seed);
      push_exp(32'h0, 1'b0, 1'b0, seed);
      push_exp(32'h0, 1'b1, 1'b0, seed);
      send_frame(seed, 6);
      drain_and_compare(tag);
      chk({tag, ".padded"}, 64'(pad_cnt), 64'd1);
      chk({tag, ".trunc"}, 64'(trunc_cnt), 64'd0);
   endtask

   task automatic case_100(input int seed, input string tag);
      reset_mon();
      for (int b = 0; b < 16; b++) push_exp(wordbeat(seed, b), b == 15, b == 15, seed);
      send_frame(seed, 100);
      drain_and_compare(tag);
      chk({tag, ".padded"}, 64'(pad_cnt), 64'd0);
      chk({tag, ".trunc"}, 64'(trunc_cnt), 64'd1);
   endtask

   initial begin
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tid    = '0;
      s_tdest  = '0;
      s_tuser  = '0;
      rst      = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst.m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst.s_tready", 64'(s_tready), 64'd0);
      chk("rst.status_padded", 64'(status_padded), 64'd0);
      chk("rst.status_truncated", 64'(status_truncated), 64'd0);
      chk("rst.m_tdata", 64'(m_tdata), 64'd0);
      chk("rst.m_tkeep", 64'(m_tkeep), 64'd0);
      chk("rst.m_tuser", 64'(m_tuser), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      case_20(16, "t1_20w", 1'b1);
      case_6(48, "t2_6w");
      case_100(80, "t3_100w");
      case_20(112, "t3_next", 1'b0);

      reset_mon();
      for (int b = 0; b < 16; b++) push_exp(wordbeat(144, b), b == 15, 1'b0, 144);
      send_frame(144, 64);
      drain_and_compare("t4_64w");
      chk("t4_64w.trunc", 64'(trunc_cnt), 64'd0);
      chk("t4_64w.padded", 64'(pad_cnt), 64'd0);

      rand_mode = 1'b1;
      case_20(20, "t5_20w", 1'b0);
      case_6(52, "t5_6w");
      case_100(84, "t5_100w");
      case_20(116, "t5_next", 1'b0);
      rand_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("t5.stall_stability", 64'(stall_viol), 64'd0);

      // Reset lands while the 6-word frame is in PAD; only its first beat has been transferred.
      reset_mon();
      push_exp(wordbeat(200, 0), 1'b0, 1'b0, 200);
      send_frame(200, 6);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6.rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("t6.rst_s_tready", 64'(s_tready), 64'd0);
      drain_and_compare("t6_partial");
      chk("t6.padded", 64'(pad_cnt), 64'd0);
      case_20(24, "t6_after", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
